// File: rtl/pixel_config_seq.sv
// rtl/pixel_config_seq.sv - copies config words from memory into the pixel FIFO, kicks a shift and waits on BUSY
// Optional BUSY timeout is compiled in with PIXEL_CONFIG_SEQ_TIMEOUT_EN.
module pixel_config_seq #(
  parameter int ADDR_WIDTH = 10,
  parameter int TMO_WIDTH  = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  RESET,
  input  logic                  CMD_START,
  input  logic                  CMD_ABORT,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   WORD_COUNT,
  input  logic [TMO_WIDTH-1:0]  TIMEOUT,
  output logic                  MEM_RD,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  input  logic [31:0]           MEM_DATA,
  input  logic                  FIFO_FULL,
  output logic [31:0]           SRAM_DATA,
  output logic                  SRAM_WE,
  output logic                  PULSE_START,
  input  logic                  BUSY,
  output logic                  SEQ_BUSY,
  output logic                  DONE,
  output logic                  ERR_TIMEOUT
);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, KICK, WAIT_HI, WAIT_LO, FINISH} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  drain_cnt;
  logic                  rd_d1;
  logic                  busy_s1;
  logic                  busy_s2;
  logic                  waiting;
  logic                  busy_exit;
  logic                  tmo_expire;

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
    end else begin
      busy_s1 <= BUSY;
      busy_s2 <= busy_s1;
    end
  end

  assign waiting   = (state == WAIT_HI) || (state == WAIT_LO);
  assign busy_exit = ((state == WAIT_HI) && busy_s2) || ((state == WAIT_LO) && !busy_s2);

`ifdef PIXEL_CONFIG_SEQ_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_lat;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  // A latched limit of zero disables expiry entirely.
  assign tmo_expire = (tmo_lat != '0) && (tmo_cnt == TMO_WIDTH'(1));

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      tmo_lat     <= '0;
      tmo_cnt     <= '0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      if (state == IDLE && CMD_START && !CMD_ABORT) begin
        tmo_lat     <= TIMEOUT;
        ERR_TIMEOUT <= 1'b0;
      end
      if (state == KICK)
        tmo_cnt <= tmo_lat;
      else if (waiting && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - TMO_WIDTH'(1);
      if (waiting && !busy_exit && tmo_expire && !CMD_ABORT)
        ERR_TIMEOUT <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign tmo_expire     = 1'b0;
  assign ERR_TIMEOUT    = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge SYS_CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      drain_cnt   <= 1'b0;
      rd_d1       <= 1'b0;
      MEM_RD      <= 1'b0;
      MEM_ADDR    <= '0;
      SRAM_DATA   <= '0;
      SRAM_WE     <= 1'b0;
      PULSE_START <= 1'b0;
      SEQ_BUSY    <= 1'b0;
      DONE        <= 1'b0;
    end else begin
      MEM_RD      <= 1'b0;
      PULSE_START <= 1'b0;
      DONE        <= 1'b0;
      // Read data arrives one cycle after MEM_RD and is forwarded registered.
      rd_d1       <= MEM_RD;
      SRAM_WE     <= rd_d1;
      if (rd_d1)
        SRAM_DATA <= MEM_DATA;

      if (state != IDLE && CMD_ABORT) begin
        state     <= IDLE;
        SEQ_BUSY  <= 1'b0;
        remaining <= '0;
        rd_d1     <= 1'b0;
        SRAM_WE   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (CMD_START && !CMD_ABORT) begin
              addr      <= BASE_ADDR;
              remaining <= WORD_COUNT;
              SEQ_BUSY  <= 1'b1;
              state     <= (WORD_COUNT == '0) ? FINISH : LOAD;
            end
          end
          LOAD: begin
            if (remaining == '0) begin
              drain_cnt <= 1'b0;
              state     <= DRAIN;
            end else if (!FIFO_FULL) begin
              MEM_RD    <= 1'b1;
              MEM_ADDR  <= addr;
              addr      <= addr + ADDR_WIDTH'(1);
              remaining <= remaining - (ADDR_WIDTH + 1)'(1);
            end
          end
          DRAIN: begin
            if (drain_cnt)
              state <= KICK;
            else
              drain_cnt <= 1'b1;
          end
          KICK: begin
            PULSE_START <= 1'b1;
            state       <= WAIT_HI;
          end
          WAIT_HI: begin
            if (busy_s2)
              state <= WAIT_LO;
            else if (tmo_expire)
              state <= FINISH;
          end
          WAIT_LO: begin
            if (!busy_s2 || tmo_expire)
              state <= FINISH;
          end
          FINISH: begin
            DONE     <= 1'b1;
            SEQ_BUSY <= 1'b0;
            state    <= IDLE;
          end
          default: begin
            SEQ_BUSY <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pixel_config_seq.md
PIXEL_CONFIG_SEQ -- requirements
Module: pixel_config_seq

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, width of the config-memory word address.
REQ-002 SHALL have parameter TMO_WIDTH, default 16, width of the BUSY timeout counter.
REQ-003 SHALL have port SYS_CLK  input  1  single clock; every flop is rising-edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port CMD_START  input  1  one-cycle request to start a configuration run.
REQ-006 SHALL have port CMD_ABORT  input  1  one-cycle request to abort a run.
REQ-007 SHALL have port BASE_ADDR  input  ADDR_WIDTH  first word address.
REQ-008 SHALL have port WORD_COUNT  input  ADDR_WIDTH+1  number of 32-bit words to send.
REQ-009 SHALL have port TIMEOUT  input  TMO_WIDTH  BUSY wait limit in cycles; 0 = no limit.
REQ-010 SHALL have port MEM_RD / MEM_ADDR  output  1 / ADDR_WIDTH  config-memory read strobe and address.
REQ-011 SHALL have port MEM_DATA  input  32  read data, valid exactly one cycle after MEM_RD.
REQ-012 SHALL have port FIFO_FULL  input  1  programmable-full; when low, at least 3 free entries are guaranteed.
REQ-013 SHALL have port SRAM_DATA / SRAM_WE  output  32 / 1  word and write strobe to the pixel-config FIFO.
REQ-014 SHALL have port PULSE_START  output  1  one-cycle shift-start request to the pixel-config datapath.
REQ-015 SHALL have port BUSY  input  1  datapath busy, asynchronous to SYS_CLK.
REQ-016 SHALL have port SEQ_BUSY, DONE, ERR_TIMEOUT  output  1 each  run active, one-cycle completion pulse, sticky timeout flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, DRAIN, KICK, WAIT_HI, WAIT_LO, FINISH.
REQ-018 In IDLE, SHALL accept CMD_START and latch BASE_ADDR, WORD_COUNT and TIMEOUT; SHALL clear ERR_TIMEOUT and go to LOAD, or to FINISH if WORD_COUNT=0 (no PULSE_START).
REQ-019 SHALL ignore CMD_START outside IDLE.
REQ-020 In LOAD, each cycle with FIFO_FULL=0 and remaining>0 SHALL assert MEM_RD at the current address, then increment the address modulo 2^ADDR_WIDTH and decrement remaining.
REQ-021 SHALL drive SRAM_WE=1 with SRAM_DATA equal to the returned MEM_DATA exactly 2 cycles after each MEM_RD (registered); there SHALL be exactly one write per read.
REQ-022 When remaining reaches 0, SHALL go to DRAIN for 2 cycles, so the last SRAM_WE occurs in DRAIN, then go to KICK.
REQ-023 In KICK, SHALL assert PULSE_START for 1 cycle and go to WAIT_HI.
REQ-024 SHALL synchronise BUSY through 2 flops; WAIT_HI SHALL exit on synced BUSY=1 to WAIT_LO; WAIT_LO SHALL exit on synced BUSY=0 to FINISH.
REQ-025 SHALL load the timeout counter with TIMEOUT on entering WAIT_HI and decrement it each cycle in WAIT_HI or WAIT_LO; when it reaches 0, with TIMEOUT≠0, SHALL set ERR_TIMEOUT and go to FINISH.
REQ-026 In FINISH, SHALL pulse DONE for 1 cycle and return to IDLE.
REQ-027 SEQ_BUSY SHALL be 1 in every state except IDLE.
REQ-028 CMD_ABORT in any non-IDLE state SHALL return to IDLE next cycle, squash pending SRAM_WE, and give no DONE and no PULSE_START; in IDLE it SHALL have no effect, and abort SHALL win over a simultaneous CMD_START.
REQ-029 WORD_COUNT=2^ADDR_WIDTH SHALL send every address once, with the address wrapping back to BASE_ADDR.

Reset
REQ-030 RESET SHALL asynchronously force IDLE, all outputs 0, counters 0, ERR_TIMEOUT 0 and the BUSY synchroniser to 0.
REQ-031 RESET mid-run SHALL drop SRAM_WE and PULSE_START immediately, and no DONE SHALL follow.

Configuration
REQ-032 With PIXEL_CONFIG_SEQ_TIMEOUT_EN defined, the timeout logic of REQ-025 SHALL be present.
REQ-033 Without PIXEL_CONFIG_SEQ_TIMEOUT_EN, SHALL wait indefinitely for BUSY, ignore TIMEOUT, and tie ERR_TIMEOUT to 0.

Verification
REQ-034 BASE_ADDR=5, WORD_COUNT=4, FIFO_FULL=0, BUSY high 10 cycles then low -> MEM_RD at 5,6,7,8 on consecutive cycles; 4 SRAM_WE, each 2 cycles after its read; one PULSE_START; DONE once.
REQ-035 WORD_COUNT=3, FIFO_FULL high for 5 cycles after the first read -> reads stall for 5 cycles; exactly 3 SRAM_WE in order; data matches memory.
REQ-036 WORD_COUNT=0 -> no MEM_RD, no PULSE_START; DONE 2 cycles after CMD_START.
REQ-037 TIMEOUT=20, BUSY stuck low, macro defined -> ERR_TIMEOUT=1 and DONE about 20 cycles after PULSE_START; ERR_TIMEOUT clears on next CMD_START.
REQ-038 BASE_ADDR=1022, WORD_COUNT=4, ADDR_WIDTH=10 -> addresses 1022,1023,0,1.
REQ-039 CMD_ABORT in the 2nd LOAD cycle -> IDLE next cycle; no further SRAM_WE; no DONE; a new CMD_START runs normally.
